bcd_calculator_seq: RTL and testbench

Clocked, parametrised successor to the team's 4-digit keypad BCD adder. Accepts keypad codes through a valid/ready handshake and holds two DIGITS-wide BCD operands. Supports chained add and subtract, computing digit-serially (one BCD digit per cycle, LSB first). Drives a blank-suppressed BCD display bus, and sits between the keypad scanner and the 7-segment display driver.

---
 rtl/bcd_calculator_seq.sv | 204 ++++++++++++++++++++
 tb/tb_bcd_calculator_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_calculator_seq.sv
// Keypad-driven BCD add/subtract calculator, digit-serial LSB-first datapath.
// Drives a blank-suppressed BCD display bus for the 7-segment driver.
module bcd_calculator_seq #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    input  logic [3:0]          key,
    output logic                key_ready,
    output logic [4*DIGITS-1:0] disp,
    output logic                error,
    output logic                busy
);
    localparam int W = 4 * DIGITS;
    localparam logic [3:0] K_SUB = 4'hA;
    localparam logic [3:0] K_ADD = 4'hC;
    localparam logic [3:0] K_EQ  = 4'hE;
    localparam logic [3:0] K_CLR = 4'hF;
    localparam logic [3:0] LAST  = 4'(DIGITS - 1);
    localparam logic [3:0] FULL  = 4'(DIGITS);
    localparam logic [W-1:0] DISP_RST = {{(DIGITS-1){4'hF}}, 4'h0};
    localparam logic [W-1:0] DISP_ERR = {{(DIGITS-1){4'hF}}, 4'hE};

    typedef enum logic [2:0] {
        S_ENTER_A, S_ENTER_B, S_CALC, S_RESULT, S_ERROR
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
    logic         op_q, op_d, c_q, c_d;
    logic [1:0]   pend_q, pend_d;
    logic [3:0]   cnt_q, cnt_d, idx_q, idx_d;

    logic         acc, k_dig, k_op, k_eq, k_clr, last, dig_ok, cout;
    logic [W-1:0] oper, shifted, sum_a;
    logic [4:0]   t;
    logic [3:0]   s;

    function automatic logic [W-1:0] blank(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         lead;
        r    = v;
        lead = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && v[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
        return r;
    endfunction

    assign acc     = key_valid & key_ready;
    assign k_dig   = key <= 4'd9;
    assign k_op    = (key == K_SUB) || (key == K_ADD);
    assign k_eq    = key == K_EQ;
    assign k_clr   = key == K_CLR;
    assign last    = idx_q == LAST;
    assign oper    = (state_q == S_ENTER_A) ? a_q : b_q;
    assign shifted = {oper[W-5:0], key};
    assign dig_ok  = k_dig && !(key == 4'h0 && oper == '0) && cnt_q < FULL;

    // Operands shift right each CALC cycle; result digits fill A from the top.
    always_comb begin
        t    = '0;
        s    = '0;
        cout = 1'b0;
        if (op_q) begin
            t    = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0, c_q};
            cout = t[4];
            s    = cout ? t[3:0] + 4'd10 : t[3:0];
        end else begin
            t    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, c_q};
            cout = t > 5'd9;
            s    = cout ? t[3:0] - 4'd10 : t[3:0];
        end
    end

    assign sum_a = {s, a_q[W-1:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= DISP_RST;
            op_q    <= 1'b0;
            c_q     <= 1'b0;
            pend_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            disp_q  <= disp_d;
            op_q    <= op_d;
            c_q     <= c_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc && k_clr) begin
            state_d = S_ENTER_A;
        end else begin
            case (state_q)
                S_ENTER_A: if (acc && k_op) state_d = S_ENTER_B;
                S_ENTER_B: if (acc && (k_op || k_eq)) state_d = S_CALC;
                S_CALC: begin
                    if (last)
                        state_d = cout ? S_ERROR
                                : (pend_q[1] ? S_ENTER_B : S_RESULT);
                end
                S_RESULT: begin
                    if (acc && k_dig)     state_d = S_ENTER_A;
                    else if (acc && k_op) state_d = S_ENTER_B;
                end
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_ENTER_A;
            endcase
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        disp_d = disp_q;
        op_d   = op_q;
        c_d    = c_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        if (acc && k_clr) begin
            a_d    = '0;
            b_d    = '0;
            disp_d = DISP_RST;
            op_d   = 1'b0;
            c_d    = 1'b0;
            pend_d = '0;
            cnt_d  = '0;
            idx_d  = '0;
        end else begin
            case (state_q)
                S_ENTER_A: begin
                    if (acc && dig_ok) begin
                        a_d    = shifted;
                        cnt_d  = cnt_q + 4'd1;
                        disp_d = blank(shifted);
                    end else if (acc && k_op) begin
                        op_d  = key == K_SUB;
                        b_d   = '0;
                        cnt_d = '0;
                    end
                end
                S_ENTER_B: begin
                    if (acc && dig_ok) begin
                        b_d    = shifted;
                        cnt_d  = cnt_q + 4'd1;
                        disp_d = blank(shifted);
                    end else if (acc && (k_op || k_eq)) begin
                        pend_d = {k_op, key == K_SUB};
                        idx_d  = '0;
                        c_d    = 1'b0;
                    end
                end
                S_CALC: begin
                    a_d   = sum_a;
                    b_d   = {4'h0, b_q[W-1:4]};
                    c_d   = cout;
                    idx_d = idx_q + 4'd1;
                    if (last) begin
                        disp_d = cout ? DISP_ERR : blank(sum_a);
                        b_d    = '0;
                        cnt_d  = '0;
                        if (pend_q[1]) op_d = pend_q[0];
                    end
                end
                S_RESULT: begin
                    if (acc && k_dig) begin
                        a_d    = {{(W-4){1'b0}}, key};
                        cnt_d  = {3'b0, key != 4'h0};
                        disp_d = blank({{(W-4){1'b0}}, key});
                    end else if (acc && k_op) begin
                        op_d  = key == K_SUB;
                        b_d   = '0;
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        key_ready = state_q != S_CALC;
        busy      = state_q == S_CALC;
        error     = state_q == S_ERROR;
        disp      = disp_q;
    end

endmodule

// File: tb/tb_bcd_calculator_seq.sv
// Scoreboard bench for bcd_calculator_seq: integer reference model,
// directed keypad sequences, randomized key stream, 6-digit instance.
module tb_bcd_calculator_seq;
    localparam int ND   = 4;
    localparam int MAXV = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key = 4'h0;
    logic        key_ready, error, busy;
    logic [15:0] disp;
    logic        kv6 = 1'b0;
    logic [3:0]  k6 = 4'h0;
    logic        kr6, err6, busy6;
    logic [23:0] disp6;

    always #5 clk = ~clk;

    bcd_calculator_seq #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key),
        .key_ready(key_ready), .disp(disp), .error(error), .busy(busy)
    );

    bcd_calculator_seq #(.DIGITS(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .key_valid(kv6), .key(k6),
        .key_ready(kr6), .disp(disp6), .error(err6), .busy(busy6)
    );

    typedef struct {
        logic [15:0] disp;
        bit          err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: operands as plain integers.
    int m_mode;  // 0 entering A, 1 entering B, 2 result, 3 error
    int m_a, m_b, m_cnt, m_show;
    bit m_op;    // 1 = subtract
    int edge_no = 0;
    int busy_end = -1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(int v, int nd, bit err);
        logic [31:0] r;
        int t;
        r = '1;
        t = v;
        for (int i = 0; i < nd; i++) begin
            if (err) r[i*4 +: 4] = (i == 0) ? 4'hE : 4'hF;
            else if (i > 0 && t == 0) r[i*4 +: 4] = 4'hF;
            else r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_a = 0; m_b = 0; m_cnt = 0; m_show = 0; m_op = 0;
        busy_end = -1;
    endtask

    task automatic model_key(logic [3:0] k);
        exp_t e;
        int v, r;
        bit calc;
        logic [31:0] d;
        calc = 0;
        if (edge_no <= busy_end) return;
        if (k == 4'hF) begin
            model_reset();
        end else if (m_mode == 0 || m_mode == 1) begin
            if (k <= 9) begin
                v = (m_mode == 0) ? m_a : m_b;
                if (!(k == 0 && v == 0) && m_cnt < ND) begin
                    v = v * 10 + int'(k);
                    m_cnt++;
                    m_show = v;
                    if (m_mode == 0) m_a = v; else m_b = v;
                end
            end else if (k == 4'hA || k == 4'hC) begin
                if (m_mode == 0) begin
                    m_op = (k == 4'hA); m_b = 0; m_cnt = 0; m_mode = 1;
                end else calc = 1;
            end else if (k == 4'hE && m_mode == 1) calc = 1;
        end else if (m_mode == 2) begin
            if (k <= 9) begin
                m_a = int'(k); m_cnt = (k != 0); m_show = m_a; m_mode = 0;
            end else if (k == 4'hA || k == 4'hC) begin
                m_op = (k == 4'hA); m_b = 0; m_cnt = 0; m_mode = 1;
            end
        end
        if (calc) begin
            r = m_op ? m_a - m_b : m_a + m_b;
            busy_end = edge_no + ND;
            if (r < 0 || r >= MAXV) m_mode = 3;
            else begin
                m_a = r; m_show = r; m_b = 0; m_cnt = 0;
                if (k == 4'hE) m_mode = 2;
                else begin m_op = (k == 4'hA); m_mode = 1; end
            end
        end
        d = enc(m_show, ND, m_mode == 3);
        e.disp = d[15:0];
        e.err  = (m_mode == 3);
        e.lat  = calc ? ND : 0;
        exp_q.push_back(e);
    endtask

    // Monitor: after each accepted key, wait out busy, then compare.
    initial begin
        exp_t e;
        int n, nr;
        @(negedge clk);
        forever begin
            if (rst_n && key_valid && key_ready) begin
                n = 0; nr = 0;
                @(negedge clk);
                while (busy && n < 64) begin
                    n++;
                    if (!key_ready) nr++;
                    @(negedge clk);
                end
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got response disp %h, expected none", disp);
                end else begin
                    e = exp_q.pop_front();
                    chk("disp", disp, e.disp);
                    chk("error", error, e.err);
                    chk("busy_cycles", n, e.lat);
                    chk("ready_low_cycles", nr, e.lat);
                    chk("ready_after", key_ready, 1);
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic step(bit v, logic [3:0] k);
        key_valid = v;
        key = k;
        @(posedge clk);
        edge_no++;
        if (v) model_key(k);
        #1;
    endtask

    task automatic settle();
        int g = 0;
        while (edge_no <= busy_end && g < 50) begin
            step(0, 4'h0);
            g++;
        end
    endtask

    function automatic logic [3:0] kc(byte c);
        case (c)
            "+": return 4'hC;
            "-": return 4'hA;
            "=": return 4'hE;
            "C": return 4'hF;
            default: return 4'(c - "0");
        endcase
    endfunction

    task automatic seq(string s);
        for (int i = 0; i < s.len(); i++) begin
            step(1, kc(s[i]));
            step(0, 4'h0);
            settle();
        end
    endtask

    task automatic seq6(string s, output int n);
        n = 0;
        for (int i = 0; i < s.len(); i++) begin
            kv6 = 1'b1;
            k6 = kc(s[i]);
            @(posedge clk);
            #1;
            kv6 = 1'b0;
            n = 0;
            while (busy6 && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] d6;
        logic [3:0] k;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_disp", disp, 16'hFFF0);
        chk("rst_error", error, 0);
        chk("rst_ready", key_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_disp6", disp6, 24'hFFFFF0);

        seq("007");
        seq("C12345");
        seq("C123+45=");
        seq("C9999+1=12+");
        seq("C");
        seq("C50-7=");
        seq("C5-7=");
        seq("C10+5-3=+8=6");

        // Reset in the middle of CALC, with a key offered while busy.
        seq("C12+3");
        step(1, 4'hE);
        step(1, 4'h3);
        #1 rst_n = 1'b0;
        exp_q[exp_q.size()-1] = '{16'hFFF0, 1'b0, 1};
        model_reset();
        repeat (2) @(posedge clk);
        key_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midcalc_rst_disp", disp, 16'hFFF0);
        chk("midcalc_rst_busy", busy, 0);
        chk("midcalc_rst_ready", key_ready, 1);
        seq("5");

        // Random stream; short gaps drop keys offered during CALC.
        seq("C");
        repeat (400) begin
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) k = 4'($urandom_range(0, 9));
            step(1, k);
            repeat ($urandom_range(0, 5)) step(0, 4'h0);
        end
        step(0, 4'h0);
        settle();
        repeat (3) step(0, 4'h0);
        chk("sb_drain", exp_q.size(), 0);

        seq6("999999+1=", n);
        chk("d6_ovf_err", err6, 1);
        chk("d6_ovf_disp", disp6, 24'hFFFFFE);
        chk("d6_ovf_busy", n, 6);
        seq6("C123456-23456=", n);
        d6 = enc(100000, 6, 0);
        chk("d6_sub_disp", disp6, d6[23:0]);
        chk("d6_sub_err", err6, 0);
        chk("d6_sub_busy", n, 6);
        seq6("C1000-1000=", n);
        chk("d6_zero_disp", disp6, 24'hFFFFF0);
        chk("d6_ready", kr6, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
